// File: rtl/ff1_sync_ver.sv
// Single D flip-flop / WIDTH-bit register with synchronous active-high reset.
// Ports are declared in the order q, d, clk, rst because parent modules connect to this block by position.
module ff1_sync_ver #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst
);

    // Reset takes priority over data, and both are sampled only on the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_ff1_sync_ver.sv
// Bench for ff1_sync_ver: a 1-bit default instance and an 8-bit instance with RESET_VALUE=A5.
// Per-edge expectations go into a scoreboard queue, and a monitor checks them after each rising edge.
`timescale 1ns/1ps
module tb_ff1_sync_ver;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_push = 0;
    bit done = 1'b0;

    typedef struct {
        string      name;
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    exp_t sb[$];

    ff1_sync_ver u1 (
        .q   (q1),
        .d   (d1),
        .clk (clk),
        .rst (rst)
    );

    ff1_sync_ver #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
        .q   (q8),
        .d   (d8),
        .clk (clk),
        .rst (rst)
    );

    // Clock is low at t=0, with rising edges at 3, 13, 23, ... ns.
    initial begin
        clk = 1'b0;
        #3;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    task automatic at(input int t);
        if ($time < t) #(t - $time);
    endtask

    task automatic push(input string name, input logic e1, input logic [7:0] e8);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e8   = e8;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic check_now(input string name, input logic e1, input logic [7:0] e8);
        n_cmp++;
        if (q1 !== e1) begin
            n_err++;
            $display("FAIL %s q1: got %b expected %b at %0t", name, q1, e1, $time);
        end
        n_cmp++;
        if (q8 !== e8) begin
            n_err++;
            $display("FAIL %s q8: got %h expected %h at %0t", name, q8, e8, $time);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per rising edge while entries are pending.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_pop++;
                check_now(e.name, e.e1, e.e8);
            end
        end
    end

    // Directed stimulus; each push is the hand-computed q for the next rising edge.
    initial begin
        rst = 1'b0;
        d1  = 1'b0;
        d8  = 8'h3C;
        push("capture0", 1'b0, 8'h3C);            // edge 3
        at(4);  d1 = 1'b1;
        at(5);  d1 = 1'b0;
        at(10); d1 = 1'b1; d8 = 8'h5A;
        push("capture1", 1'b1, 8'h5A);            // edge 13
        at(12); check_now("glitch_reject", 1'b0, 8'h3C);
        at(15); d1 = 1'b0; d8 = 8'hFF;
        at(21); rst = 1'b1;
        at(22); check_now("rst_no_async", 1'b1, 8'h5A);
        push("reset_edge", 1'b0, 8'hA5);          // edge 23
        at(27); d1 = 1'b1; d8 = 8'h11;
        push("reset_priority", 1'b0, 8'hA5);      // edge 33
        at(35); rst = 1'b0; d8 = 8'h3C;
        push("reset_release", 1'b1, 8'h3C);       // edge 43
        at(45); rst = 1'b1;
        at(48); rst = 1'b0;
        at(50); check_now("rst_pulse_between", 1'b1, 8'h3C);
        push("after_rst_pulse", 1'b1, 8'h3C);     // edge 53
        at(55); d1 = 1'b0; d8 = 8'h81;
        push("capture_81", 1'b0, 8'h81);          // edge 63
        at(65); rst = 1'b1; d1 = 1'b1; d8 = 8'h00;
        push("reset_again", 1'b0, 8'hA5);         // edge 73
        push("reset_hold", 1'b0, 8'hA5);          // edge 83
        at(85); rst = 1'b0; d8 = 8'hC3;
        push("release_C3", 1'b1, 8'hC3);          // edge 93
        at(98); d1 = 1'b0; d8 = 8'h00;
        at(100); check_now("falling_edge_ignored", 1'b1, 8'hC3);
        push("capture_zero", 1'b0, 8'h00);        // edge 103
        at(107); d8 = 8'hFF;
        push("hold_d1_ff", 1'b0, 8'hFF);          // edge 113
        at(130);
        done = 1'b1;
        n_cmp++;
        if (sb.size() != 0 || n_pop != n_push) begin
            n_err++;
            $display("FAIL scoreboard_drain: popped %0d of %0d expected entries", n_pop, n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
